mmio_tx_fifo: RTL
=================

// Module: mmio_tx_fifo
// PURPOSE
//   Memory-mapped responder on the ARM single-cycle data bus (MemWrite/DataAdr/WriteData/ReadData), beside dmem.
//   Processor stores to DATA push words into a FIFO; a downstream consumer drains them over valid/ready.
//   Also provides STATUS (count/empty/full/overflow) and CTRL (clear overflow, flush) registers.
//   Top level muxes ReadData: this block's rdata when hit=1, else dmem.
// PARAMETERS
//   BASE_ADDR  32'hFFFF_0000  16-byte-aligned window base; decode on DataAdr[31:4]
//   DEPTH      8              FIFO entries; power of two, >= 2
//   DW         32             data width; fixed at 32 for the ARM bus
// PORTS
//   clk        in   1         single clock; all state updates on rising edge
//   reset      in   1         synchronous, active-high
//   MemWrite   in   1         store strobe from processor
//   DataAdr    in   32        byte address from processor
//   WriteData  in   32        store data from processor
//   rdata      out  32        load data; combinational from DataAdr and state
//   hit        out  1         DataAdr inside window; combinational
//   out_valid  out  1         FIFO head valid (= !empty)
//   out_data   out  DW        FIFO head word
//   out_ready  in   1         consumer accepts head this cycle
// BEHAVIOUR
//   Decode: hit = (DataAdr[31:4] == BASE_ADDR[31:4]); reg = DataAdr[3:2]; DataAdr[1:0] ignored.
//   Map: 0 DATA (W: push; R: 0); 1 STATUS (RO); 2 CTRL (W; R: 0); 3 reserved (R: 0, W ignored).
//   STATUS = {16'b0, count[7:0], 5'b0, ovf, full, empty}; count width $clog2(DEPTH)+1, zero-extended.
//   CTRL write: bit0=1 clears ovf; bit1=1 flushes FIFO (count/pointers -> 0). Other bits ignored.
//   rdata = 0 when hit=0. Reads have no side effects; read of STATUS reflects pre-edge state.
//   push = MemWrite & hit & reg==0; pop = out_valid & out_ready.
//   Latency: word pushed at edge N is visible on out_data/out_valid after edge N (cycle N+1).
//   out_data = mem[rd_ptr]; stays stable while out_valid=1 and out_ready=0.
//   Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
//   full & push & !pop -> word dropped, ovf<=1 (sticky until CTRL bit0 or reset).
//   full & push & pop -> both performed, count unchanged, no overflow.
//   empty & push & out_ready -> push only (out_valid was 0, no pop); count 0->1.
//   push & pop, not full/empty -> both performed, count unchanged.
//   Flush same cycle as pop: flush wins; consumer handshake still counts as taken by consumer.
//   Flush and push cannot coincide (different regs); ovf clear and set cannot coincide.
//   Reset (any cycle, incl. mid-burst): pointers=0, count=0, ovf=0 -> out_valid=0, STATUS=32'h1;
//     mem contents undefined, out_data don't-care while out_valid=0. Reset overrides all bus activity.
//   No X on rdata/hit/out_valid after reset for any DataAdr.
// TESTING
//   Reset, read BASE+4 -> rdata=32'h0000_0001, hit=1, out_valid=0; read 32'h0000_0010 -> hit=0, rdata=0.
//   Store 0xA,0xB,0xC to BASE+0 with out_ready=0 -> STATUS=32'h0000_0300; raise out_ready -> out_data A,B,C on 3 cycles, then out_valid=0.
//   Push 9 words (DEPTH=8), ready=0 -> STATUS=32'h0000_0806 (count 8, full, ovf); 9th word never emerges; CTRL write 1 -> ovf=0.
//   Full FIFO, push 0x55 with out_ready=1 same cycle -> count stays 8, ovf=0, 0x55 emerges 8th after current head.
//   Push 16 words with out_ready=1 continuously -> pointers wrap twice, output order exact, never full.
//   3 words queued, assert reset one cycle mid-drain -> next cycle STATUS=32'h1, out_valid=0; CTRL bit1 flush behaves likewise.

Source files
------------

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo
//   Memory-mapped transmit FIFO that sits on the ARM single-cycle data bus
//   next to dmem. Processor stores to DATA push words into the FIFO, and a
//   downstream consumer drains them through a valid/ready handshake.
//   The STATUS register reports occupancy, empty, full and a sticky overflow
//   flag. The CTRL register can clear the overflow flag and flush the FIFO.
//
//   Register window (16 bytes at BASE_ADDR, word index DataAdr[3:2]):
//     0 DATA   write pushes WriteData, reads return 0
//     1 STATUS read only: {16'b0, count[7:0], 5'b0, ovf, full, empty}
//     2 CTRL   write bit0 = clear ovf, bit1 = flush; reads return 0
//     3 reserved, reads return 0 and writes are ignored
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high
//   MemWrite   store strobe from the processor
//   DataAdr    byte address from the processor
//   WriteData  store data from the processor
//   rdata      load data, combinational; 0 outside the window
//   hit        DataAdr falls inside the window (combinational)
//   out_valid  FIFO head is valid (FIFO not empty)
//   out_data   FIFO head word
//   out_ready  consumer accepts the head word this cycle
module mmio_tx_fifo #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          DEPTH     = 8,
   parameter int          DW        = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWrite,
   input  logic [31:0]   DataAdr,
   input  logic [31:0]   WriteData,
   output logic [31:0]   rdata,
   output logic          hit,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          ovf_reg, ovf_next;

   logic [3:0]    sel;
   logic          empty, full;
   logic          push_req, do_push, pop, ovf_set;
   logic          ctrl_wr, flush, ovf_clr;
   logic [7:0]    count8;
   logic [31:0]   status;
   logic          unused_adr_bits;

   // Byte offset within a word has no meaning for this block.
   assign unused_adr_bits = ^DataAdr[1:0];

   assign hit = (DataAdr[31:4] == BASE_ADDR[31:4]);

   // One-hot register select, already qualified by hit.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sel
         assign sel[gi] = hit & (DataAdr[3:2] == 2'(gi));
      end
   endgenerate

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CW'(DEPTH));
   assign out_valid = ~empty;
   assign out_data  = mem[rd_ptr_reg];

   assign push_req = MemWrite & sel[0];
   assign ctrl_wr  = MemWrite & sel[2];
   assign flush    = ctrl_wr & WriteData[1];
   assign ovf_clr  = ctrl_wr & WriteData[0];

   assign pop      = out_valid & out_ready;
   // A push into a full FIFO still fits when the head leaves the same cycle.
   assign do_push  = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   assign count8 = 8'(count_reg);
   assign status = {16'b0, count8, 5'b0, ovf_reg, full, empty};
   assign rdata  = sel[1] ? status : 32'h0;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      ovf_next    = ovf_reg;

      if (flush) begin
         // Flush beats a simultaneous pop; the consumer still took its word.
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
         if (pop)     rd_ptr_next = rd_ptr_reg + PW'(1);
         case ({do_push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end

      if (ovf_clr)      ovf_next = 1'b0;
      else if (ovf_set) ovf_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         ovf_reg    <= ovf_next;
      end
   end

   // Storage has no reset; contents are only observed while out_valid=1.
   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr_reg] <= WriteData[DW-1:0];
      end
   end

endmodule
